// File: rtl/tictactoe_game.sv
// Two-player tic-tac-toe game controller: a cursor and select button place marks,
// a one-cycle CHECK state detects a win or a draw, and OVER waits for a restart.
// Optional feature macro: TURN_TIMEOUT_EN. When it is defined, a player who stays
// idle for TIMEOUT_CYCLES cycles has their mark placed automatically.
module tictactoe_game #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_move,
   input  logic        btn_select,
   output logic [17:0] board,
   output logic [3:0]  cursor,
   output logic        turn,
   output logic [1:0]  winner,
   output logic        game_over,
   output logic        draw
);

   localparam logic [1:0] PLAY  = 2'd0;
   localparam logic [1:0] CHECK = 2'd1;
   localparam logic [1:0] OVER  = 2'd2;
   localparam int unsigned CELLS = 9;

   logic [1:0]  state, state_nx;
   logic        move_q, select_q;
   logic        move_ev_c, select_ev_c;
   logic [17:0] board_nx;
   logic [3:0]  cursor_nx;
   logic        turn_nx, draw_nx;
   logic [1:0]  winner_nx;
   logic [1:0]  code_c;
   logic        place_c, full_c, line_c, timeout_c;
   logic [3:0]  place_idx_c, empty_idx_c;

   // Return 1 when any row, column or diagonal holds three cells equal to code.
   function automatic logic has_line(input logic [17:0] b, input logic [1:0] code);
      logic [8:0] m;
      for (int i = 0; i < 9; i++) m[i] = (b[2*i +: 2] == code);
      return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
             (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
             (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
   endfunction

   assign move_ev_c   = btn_move & ~move_q;
   assign select_ev_c = btn_select & ~select_q;
   assign code_c      = turn ? 2'b10 : 2'b01;
   assign line_c      = has_line(board, code_c);

   // Board is full when every cell holds a non-empty code.
   always_comb begin
      full_c = 1'b1;
      for (int i = 0; i < int'(CELLS); i++) full_c &= |board[2*i +: 2];
   end

`ifdef TURN_TIMEOUT_EN
   logic [31:0] idle_cnt;

   // Lowest-index empty cell, the target of an automatic move.
   always_comb begin
      empty_idx_c = 4'd0;
      for (int i = int'(CELLS) - 1; i >= 0; i--)
         if (board[2*i +: 2] == 2'b00) empty_idx_c = 4'(i);
   end

   assign timeout_c = (state == PLAY) && !move_ev_c && !select_ev_c &&
                      (idle_cnt == TIMEOUT_CYCLES - 32'd1);

   // Idle cycle counter, active only while waiting in PLAY.
   always_ff @(posedge clk) begin
      if (rst) idle_cnt <= 32'd0;
      else if (state != PLAY || move_ev_c || select_ev_c || timeout_c) idle_cnt <= 32'd0;
      else idle_cnt <= idle_cnt + 32'd1;
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign timeout_c      = 1'b0;
   assign empty_idx_c    = 4'd0;
`endif

   // State register and edge-detect copies of the buttons.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= PLAY;
         move_q   <= 1'b0;
         select_q <= 1'b0;
      end else begin
         state    <= state_nx;
         move_q   <= btn_move;
         select_q <= btn_select;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nx    = state;
      board_nx    = board;
      cursor_nx   = cursor;
      turn_nx     = turn;
      winner_nx   = winner;
      draw_nx     = draw;
      place_c     = 1'b0;
      place_idx_c = cursor;
      case (state)
         PLAY: begin
            if (select_ev_c) begin
               if (board[{cursor, 1'b0} +: 2] == 2'b00) place_c = 1'b1;
            end else if (move_ev_c) begin
               cursor_nx = (cursor == 4'd8) ? 4'd0 : cursor + 4'd1;
            end else if (timeout_c) begin
               place_c     = 1'b1;
               place_idx_c = empty_idx_c;
               cursor_nx   = empty_idx_c;
            end
            if (place_c) begin
               board_nx[{place_idx_c, 1'b0} +: 2] = code_c;
               state_nx = CHECK;
            end
         end
         CHECK: begin
            if (line_c) begin
               winner_nx = code_c;
               state_nx  = OVER;
            end else if (full_c) begin
               draw_nx  = 1'b1;
               state_nx = OVER;
            end else begin
               turn_nx  = ~turn;
               state_nx = PLAY;
            end
         end
         OVER: begin
            if (select_ev_c) begin
               board_nx  = 18'd0;
               cursor_nx = 4'd0;
               turn_nx   = 1'b0;
               winner_nx = 2'b00;
               draw_nx   = 1'b0;
               state_nx  = PLAY;
            end
         end
         default: state_nx = PLAY;
      endcase
   end

   // Registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         board     <= 18'd0;
         cursor    <= 4'd0;
         turn      <= 1'b0;
         winner    <= 2'b00;
         game_over <= 1'b0;
         draw      <= 1'b0;
      end else begin
         board     <= board_nx;
         cursor    <= cursor_nx;
         turn      <= turn_nx;
         winner    <= winner_nx;
         game_over <= (state_nx == OVER);
         draw      <= draw_nx;
      end
   end

endmodule

// File: tb/tb_tictactoe_game.sv
// Self-checking bench for tictactoe_game: a table of button presses with the
// expected settled outputs, plus hand-written multi-cycle sequences.
module tb_tictactoe_game;

`ifdef TURN_TIMEOUT_EN
   localparam logic [31:0] TO = 32'd16;
`else
   localparam logic [31:0] TO = 32'd250_000_000;
`endif

   logic        clk = 1'b0;
   logic        rst, btn_move, btn_select;
   logic [17:0] board;
   logic [3:0]  cursor;
   logic        turn, game_over, draw;
   logic [1:0]  winner;

   tictactoe_game #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .btn_move(btn_move), .btn_select(btn_select),
      .board(board), .cursor(cursor), .turn(turn), .winner(winner),
      .game_over(game_over), .draw(draw)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        mv;
      logic        sel;
      int          reps;
      logic [17:0] board;
      logic [3:0]  cursor;
      logic        turn;
      logic [1:0]  winner;
      logic        over;
      logic        draw;
   } vec_t;

   typedef struct {
      string       name;
      logic [17:0] board;
      logic [3:0]  cursor;
      logic        turn;
      logic [1:0]  winner;
      logic        over;
      logic        draw;
   } exp_t;

   vec_t tbl[$];
   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t v(input logic mv, input logic sel, input int reps,
                              input logic [17:0] b, input logic [3:0] c, input logic t,
                              input logic [1:0] w, input logic o, input logic d);
      vec_t r;
      r.mv = mv; r.sel = sel; r.reps = reps; r.board = b; r.cursor = c;
      r.turn = t; r.winner = w; r.over = o; r.draw = d;
      return r;
   endfunction

   task automatic expect_out(input string name, input logic [17:0] b, input logic [3:0] c,
                             input logic t, input logic [1:0] w, input logic o, input logic d);
      exp_t e;
      e.name = name; e.board = b; e.cursor = c; e.turn = t;
      e.winner = w; e.over = o; e.draw = d;
      exp_q.push_back(e);
   endtask

   task automatic check();
      exp_t e;
      if (exp_q.size() == 0) begin
         n_vec++; n_err++;
         $display("FAIL scoreboard: no expected entry queued");
         return;
      end
      e = exp_q.pop_front();
      n_vec++;
      if (board !== e.board || cursor !== e.cursor || turn !== e.turn ||
          winner !== e.winner || game_over !== e.over || draw !== e.draw) begin
         n_err++;
         $display("FAIL %s: got board=%05h cursor=%0d turn=%b winner=%b over=%b draw=%b, expected board=%05h cursor=%0d turn=%b winner=%b over=%b draw=%b",
                  e.name, board, cursor, turn, winner, game_over, draw,
                  e.board, e.cursor, e.turn, e.winner, e.over, e.draw);
      end
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1; btn_move = 1'b0; btn_select = 1'b0;
      @(negedge clk); rst = 1'b0;
   endtask

   // One press: level high for one cycle, then two idle cycles so CHECK settles.
   task automatic press(input logic m, input logic s);
      @(negedge clk); btn_move = m; btn_select = s;
      @(negedge clk); btn_move = 1'b0; btn_select = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; btn_move = 1'b0; btn_select = 1'b0;

      // Basic place/occupied/wrap, a P1 win on the top row, then a full-board draw.
      tbl.push_back(v(0,1,1,18'h00001,4'd0,1'b1,2'b00,1'b0,1'b0));
      tbl.push_back(v(0,1,1,18'h00001,4'd0,1'b1,2'b00,1'b0,1'b0));
      tbl.push_back(v(1,0,9,18'h00001,4'd0,1'b1,2'b00,1'b0,1'b0));
      tbl.push_back(v(1,0,3,18'h00001,4'd3,1'b1,2'b00,1'b0,1'b0));
      tbl.push_back(v(0,1,1,18'h00081,4'd3,1'b0,2'b00,1'b0,1'b0));
      tbl.push_back(v(1,0,7,18'h00081,4'd1,1'b0,2'b00,1'b0,1'b0));
      tbl.push_back(v(0,1,1,18'h00085,4'd1,1'b1,2'b00,1'b0,1'b0));
      tbl.push_back(v(1,0,3,18'h00085,4'd4,1'b1,2'b00,1'b0,1'b0));
      tbl.push_back(v(0,1,1,18'h00285,4'd4,1'b0,2'b00,1'b0,1'b0));
      tbl.push_back(v(1,0,7,18'h00285,4'd2,1'b0,2'b00,1'b0,1'b0));
      tbl.push_back(v(0,1,1,18'h00295,4'd2,1'b0,2'b01,1'b1,1'b0));
      tbl.push_back(v(1,0,1,18'h00295,4'd2,1'b0,2'b01,1'b1,1'b0));
      tbl.push_back(v(0,1,1,18'h00000,4'd0,1'b0,2'b00,1'b0,1'b0));
      tbl.push_back(v(0,1,1,18'h00001,4'd0,1'b1,2'b00,1'b0,1'b0));
      tbl.push_back(v(1,0,1,18'h00001,4'd1,1'b1,2'b00,1'b0,1'b0));
      tbl.push_back(v(0,1,1,18'h00009,4'd1,1'b0,2'b00,1'b0,1'b0));
      tbl.push_back(v(1,0,1,18'h00009,4'd2,1'b0,2'b00,1'b0,1'b0));
      tbl.push_back(v(0,1,1,18'h00019,4'd2,1'b1,2'b00,1'b0,1'b0));
      tbl.push_back(v(1,0,2,18'h00019,4'd4,1'b1,2'b00,1'b0,1'b0));
      tbl.push_back(v(0,1,1,18'h00219,4'd4,1'b0,2'b00,1'b0,1'b0));
      tbl.push_back(v(1,0,8,18'h00219,4'd3,1'b0,2'b00,1'b0,1'b0));
      tbl.push_back(v(0,1,1,18'h00259,4'd3,1'b1,2'b00,1'b0,1'b0));
      tbl.push_back(v(1,0,2,18'h00259,4'd5,1'b1,2'b00,1'b0,1'b0));
      tbl.push_back(v(0,1,1,18'h00A59,4'd5,1'b0,2'b00,1'b0,1'b0));
      tbl.push_back(v(1,0,2,18'h00A59,4'd7,1'b0,2'b00,1'b0,1'b0));
      tbl.push_back(v(0,1,1,18'h04A59,4'd7,1'b1,2'b00,1'b0,1'b0));
      tbl.push_back(v(1,0,8,18'h04A59,4'd6,1'b1,2'b00,1'b0,1'b0));
      tbl.push_back(v(0,1,1,18'h06A59,4'd6,1'b0,2'b00,1'b0,1'b0));
      tbl.push_back(v(1,0,2,18'h06A59,4'd8,1'b0,2'b00,1'b0,1'b0));
      tbl.push_back(v(0,1,1,18'h16A59,4'd8,1'b0,2'b00,1'b1,1'b1));
      tbl.push_back(v(0,1,1,18'h00000,4'd0,1'b0,2'b00,1'b0,1'b0));

      do_reset();
      expect_out("reset", 18'h0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0);
      check();

      foreach (tbl[i]) begin
         expect_out($sformatf("vec%0d", i), tbl[i].board, tbl[i].cursor, tbl[i].turn,
                    tbl[i].winner, tbl[i].over, tbl[i].draw);
         for (int r = 0; r < tbl[i].reps; r++) press(tbl[i].mv, tbl[i].sel);
         check();
      end

      // Board visible one cycle after the select edge; turn toggles one cycle later.
      do_reset();
      @(negedge clk); btn_select = 1'b1;
      @(negedge clk);
      expect_out("write_latency", 18'h00001, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0);
      check();
      btn_select = 1'b0;
      @(negedge clk);
      expect_out("turn_latency", 18'h00001, 4'd0, 1'b1, 2'b00, 1'b0, 1'b0);
      check();

      // A held move button yields a single cursor step.
      btn_move = 1'b1;
      repeat (3) @(negedge clk);
      btn_move = 1'b0;
      @(negedge clk);
      expect_out("held_move", 18'h00001, 4'd1, 1'b1, 2'b00, 1'b0, 1'b0);
      check();

      // Move and select in the same cycle: select wins, cursor stays.
      do_reset();
      repeat (4) press(1'b1, 1'b0);
      press(1'b1, 1'b1);
      expect_out("simultaneous", 18'h00100, 4'd4, 1'b1, 2'b00, 1'b0, 1'b0);
      check();

      // Reset while in CHECK abandons the game.
      press(1'b1, 1'b0);
      @(negedge clk); btn_select = 1'b1;
      @(negedge clk); btn_select = 1'b0; rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      expect_out("rst_in_check", 18'h0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0);
      check();

`ifdef TURN_TIMEOUT_EN
      // Idle for the timeout: P1's mark lands on the lowest empty cell.
      do_reset();
      repeat (18) @(negedge clk);
      expect_out("timeout", 18'h00001, 4'd0, 1'b1, 2'b00, 1'b0, 1'b0);
      check();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tictactoe_game.md
TICTACTOE_GAME -- requirements
Module: tictactoe_game

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd250_000_000, meaning the idle cycles in PLAY before an automatic move (used only with TURN_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1, system clock; one clock domain, all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port btn_move, input, 1, cursor-advance button; level, already synchronized and debounced.
REQ-005 SHALL have port btn_select, input, 1, place-mark / restart button; level, already synchronized and debounced.
REQ-006 SHALL have port board, output, 18, cell i at bits [2i+1:2i]: 00 empty, 01 player 1 (X), 10 player 2 (O); 11 never driven.
REQ-007 SHALL have port cursor, output, 4, selected cell index 0..8, row-major.
REQ-008 SHALL have port turn, output, 1, 0 = player 1 to move, 1 = player 2 to move.
REQ-009 SHALL have port winner, output, 2, 00 none, 01 player 1, 10 player 2.
REQ-010 SHALL have port game_over, output, 1, high in OVER state.
REQ-011 SHALL have port draw, output, 1, high in OVER when the board is full and there is no winner.

Function
REQ-012 SHALL detect rising edges of btn_move and btn_select by comparing each with a registered copy; one press gives one event.
REQ-013 SHALL implement FSM states PLAY, CHECK, OVER.
REQ-014 PLAY, move event: cursor := (cursor==8) ? 0 : cursor+1, registered on the next edge.
REQ-015 PLAY, select event on an empty cursor cell: write 01 (turn=0) or 10 (turn=1) into that cell; go to CHECK.
REQ-016 PLAY, select event on an occupied cell: no change; stay in PLAY.
REQ-017 Simultaneous move and select events: select wins; move event discarded.
REQ-018 CHECK lasts exactly one cycle: evaluate 3 rows, 3 columns and 2 diagonals for the mover's code.
REQ-019 CHECK, line complete: winner := mover, go to OVER; turn unchanged.
REQ-020 CHECK, no line and all 9 cells non-empty: draw := 1, go to OVER.
REQ-021 CHECK, otherwise: toggle turn; return to PLAY.
REQ-022 Button events arriving during CHECK SHALL be discarded.
REQ-023 OVER: move events ignored; select event clears board, winner, draw; sets cursor=0, turn=0; go to PLAY.
REQ-024 Outputs SHALL be registered; a board write is visible one cycle after the select edge is sampled.
REQ-025 board SHALL be stable except on the cycle it is written or cleared; the downstream renderer reads it asynchronously to pixel position.

Reset
REQ-026 rst SHALL take priority over all events; on the next clk edge: state=PLAY, board=0, cursor=0, turn=0, winner=00, game_over=0, draw=0, edge registers=0, timeout counter=0.
REQ-027 rst asserted mid-game or in CHECK SHALL abandon the game with no partial write.

Configuration
REQ-028 Macro TURN_TIMEOUT_EN defined: a counter SHALL count cycles in PLAY and clear on any accepted move/select event, on entering PLAY, and on reset.
REQ-029 With TURN_TIMEOUT_EN, at count TIMEOUT_CYCLES-1 the block SHALL place the mover's mark in the lowest-index empty cell, set cursor to that index, and go to CHECK.
REQ-030 TURN_TIMEOUT_EN undefined: no counter is synthesized; PLAY waits indefinitely; TIMEOUT_CYCLES is unused.

Verification
REQ-031 Reset, then select -> board=18'h00001, turn=1 two cycles later, cursor=0.
REQ-032 P1 takes cells 0,1,2 and P2 takes 3,4 (move presses between selects) -> after the 5th select: winner=01, game_over=1; then select -> board=0, turn=0, cursor=0.
REQ-033 Full board X O X / X O O / O X X -> draw=1, winner=00, game_over=1.
REQ-034 Select on occupied cell 0 -> board unchanged, turn unchanged; 9 move presses from cursor 0 -> cursor wraps back to 0.
REQ-035 Move and select rising in the same cycle at cursor 4 -> mark placed at cell 4, cursor stays 4; rst pulse in CHECK -> all outputs zero.
REQ-036 With TURN_TIMEOUT_EN and TIMEOUT_CYCLES=16: no input for 16 cycles after reset -> cell 0 = 01, turn=1.
